l1a_fifo_writer: RTL and testbench

//  Producer end of the L1A FIFO drained by the L1A checker. Packs each accepted L1A (number,

---
 rtl/l1a_fifo_writer.sv | 129 ++++++++++++
 tb/tb_l1a_fifo_writer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/l1a_fifo_writer.sv
// l1a_fifo_writer: queues accepted L1As and writes each as a 3/4-word record into the L1A FIFO.
module l1a_fifo_writer #(
    parameter int QDEPTH = 2,
    parameter int DCW    = 8
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           l1a_i,
    input  logic [23:0]    l1a_num_i,
    input  logic [11:0]    bxn_i,
    input  logic           alct_flg_i,
    input  logic           tmb_flg_i,
    input  logic [4:0]     cfeb_mask_i,
    input  logic           fifo_full_i,
    output logic           fifo_we_o,
    output logic [15:0]    fifo_din_o,
    output logic           busy_o,
    output logic           l1a_drop_o,
    output logic [DCW-1:0] l1a_drop_cnt_o
);
    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0] QFULL = (AW+1)'(QDEPTH);

    typedef struct packed {
        logic [23:0] num;
        logic [11:0] bxn;
        logic        alct;
        logic        tmb;
        logic [4:0]  mask;
    } ent_t;

    typedef enum logic [2:0] {IDLE, WR_B4, WR_L1L, WR_L1H, WR_B5} st_t;

    st_t            state_q, state_d;
    ent_t           mem_q [QDEPTH];
    ent_t           rec_q, head;
    logic [AW-1:0]  wp_q, rp_q;
    logic [AW:0]    cnt_q;
    logic [15:0]    dout_q, dout_d;
    logic           drop_q;
    logic [DCW-1:0] drop_cnt_q;
    logic           q_empty, q_full, push, drop, pop;

    function automatic logic [15:0] b4_word(input ent_t e);
        return {4'hB, e.alct | e.tmb, e.mask, e.alct, e.tmb, 4'h0};
    endfunction

    assign head    = mem_q[rp_q];
    assign q_empty = cnt_q == '0;
    assign q_full  = cnt_q == QFULL;
    assign push    = l1a_i && !q_full;
    assign drop    = l1a_i && q_full;

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wp_q] <= '{l1a_num_i, bxn_i, alct_flg_i, tmb_flg_i, cfeb_mask_i};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wp_q       <= '0;
            rp_q       <= '0;
            cnt_q      <= '0;
            state_q    <= IDLE;
            rec_q      <= '0;
            dout_q     <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wp_q       <= push ? wp_q + 1'b1 : wp_q;
            rp_q       <= pop ? rp_q + 1'b1 : rp_q;
            cnt_q      <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            state_q    <= state_d;
            rec_q      <= pop ? head : rec_q;
            dout_q     <= dout_d;
            drop_q     <= drop;
            drop_cnt_q <= (drop && drop_cnt_q != {DCW{1'b1}}) ? drop_cnt_q + 1'b1 : drop_cnt_q;
        end
    end

    // Every state transition out of a write state is gated by a completed (unstalled) write.
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (!q_empty) begin
                pop     = 1'b1;
                state_d = WR_B4;
                dout_d  = b4_word(head);
            end
            WR_B4: if (!fifo_full_i) begin
                state_d = WR_L1L;
                dout_d  = {4'hC, rec_q.num[11:0]};
            end
            WR_L1L: if (!fifo_full_i) begin
                state_d = WR_L1H;
                dout_d  = {4'hD, rec_q.num[23:12]};
            end
            WR_L1H: if (!fifo_full_i) begin
                if (rec_q.alct || rec_q.tmb) begin
                    state_d = WR_B5;
                    dout_d  = {4'hE, rec_q.bxn};
                end else if (!q_empty) begin
                    pop     = 1'b1;
                    state_d = WR_B4;
                    dout_d  = b4_word(head);
                end else begin
                    state_d = IDLE;
                end
            end
            WR_B5: if (!fifo_full_i) begin
                if (!q_empty) begin
                    pop     = 1'b1;
                    state_d = WR_B4;
                    dout_d  = b4_word(head);
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fifo_we_o      = rst_n_i && state_q != IDLE && !fifo_full_i;
    assign fifo_din_o     = dout_q;
    assign busy_o         = state_q != IDLE || !q_empty;
    assign l1a_drop_o     = drop_q;
    assign l1a_drop_cnt_o = drop_cnt_q;
endmodule

// File: tb/tb_l1a_fifo_writer.sv
// tb_l1a_fifo_writer: directed stimulus with a scoreboard of expected FIFO words checked by a monitor.
module tb_l1a_fifo_writer;
    logic        clk = 1'b0;
    logic        rst_n, l1a, alct, tmb, full;
    logic [23:0] num;
    logic [11:0] bxn;
    logic [4:0]  mask;
    logic        we, we2, busy, busy2, drop, drop2;
    logic [15:0] din, din2;
    logic [7:0]  cnt;
    logic [1:0]  cnt2;
    logic [15:0] exp_q[$];
    logic [13:0] wv;
    int          npass = 0, ntot = 0;

    always #5 clk = ~clk;

    l1a_fifo_writer #(.QDEPTH(2), .DCW(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .l1a_i(l1a), .l1a_num_i(num), .bxn_i(bxn),
        .alct_flg_i(alct), .tmb_flg_i(tmb), .cfeb_mask_i(mask), .fifo_full_i(full),
        .fifo_we_o(we), .fifo_din_o(din), .busy_o(busy), .l1a_drop_o(drop), .l1a_drop_cnt_o(cnt)
    );

    l1a_fifo_writer #(.QDEPTH(2), .DCW(2)) dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .l1a_i(l1a), .l1a_num_i(num), .bxn_i(bxn),
        .alct_flg_i(alct), .tmb_flg_i(tmb), .cfeb_mask_i(mask), .fifo_full_i(full),
        .fifo_we_o(we2), .fifo_din_o(din2), .busy_o(busy2), .l1a_drop_o(drop2), .l1a_drop_cnt_o(cnt2)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        ntot++;
        if (act === expv) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [23:0] n, input logic [11:0] b, input logic a, input logic t,
                          input logic [4:0] m);
        num = n; bxn = b; alct = a; tmb = t; mask = m; l1a = 1'b1;
    endtask

    task automatic issue(input logic [23:0] n, input logic [11:0] b, input logic a, input logic t,
                         input logic [4:0] m, input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] w2, input logic [15:0] w3, input bit has_b5);
        set_in(n, b, a, t, m);
        exp_q.push_back(w0);
        exp_q.push_back(w1);
        exp_q.push_back(w2);
        if (has_b5) exp_q.push_back(w3);
    endtask

    task automatic do_reset();
        cyc();
        rst_n = 1'b0; full = 1'b0; l1a = 1'b0;
        cyc();
        @(negedge clk);
        check("rst_we", we, 0);
        check("rst_busy", busy, 0);
        check("rst_din", din, 0);
        check("rst_drop", drop, 0);
        check("rst_cnt", cnt, 0);
        check("rst_cnt2", cnt2, 0);
        cyc();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (we) begin
            if (exp_q.size() == 0) begin
                ntot++;
                $display("FAIL unexpected_write: got din=%0h expected no write", din);
            end else begin
                check("fifo_din", din, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; l1a = 1'b0; full = 1'b0; alct = 1'b0; tmb = 1'b0;
        num = '0; bxn = '0; mask = '0;
        do_reset();

        // single record with B5, exact latency and back-to-back word cycles
        issue(24'h123456, 12'hABC, 1, 0, 5'h05, 16'hB960, 16'hC456, 16'hD123, 16'hEABC, 1);
        cyc(); l1a = 1'b0;
        wv = '0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); wv[i] = we; end
        check("t1_we_pattern", wv[5:0], 6'b011110);
        check("t1_busy_end", busy, 0);

        // 3-word record
        cyc();
        issue(24'h000001, 12'h000, 0, 0, 5'h00, 16'hB000, 16'hC001, 16'hD000, 16'h0000, 0);
        cyc(); l1a = 1'b0;
        wv = '0;
        for (int i = 0; i < 5; i++) begin @(negedge clk); wv[i] = we; end
        check("t2_we_pattern", wv[4:0], 5'b01110);
        check("t2_busy_end", busy, 0);

        // FULL stall of 5 cycles in Wr_L1L
        cyc();
        issue(24'hABCDEF, 12'h5A5, 0, 1, 5'h1F, 16'hBFD0, 16'hCDEF, 16'hDABC, 16'hE5A5, 1);
        cyc(); l1a = 1'b0;
        cyc(); cyc();
        full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_stall_we", we, 0);
            check("t3_stall_din", din, 16'hCDEF);
            cyc();
        end
        full = 1'b0;
        repeat (5) cyc();
        check("t3_busy_end", busy, 0);

        // four consecutive L1As, fourth dropped, three records back-to-back
        issue(24'h000010, 12'h000, 0, 0, 5'h01, 16'hB040, 16'hC010, 16'hD000, 16'h0000, 0);
        wv = '0;
        for (int i = 0; i < 14; i++) begin
            cyc();
            if (i == 0) issue(24'h345678, 12'h000, 0, 0, 5'h10, 16'hB400, 16'hC678, 16'hD345, 16'h0000, 0);
            if (i == 1) issue(24'hFFFFFF, 12'h000, 0, 0, 5'h00, 16'hB000, 16'hCFFF, 16'hDFFF, 16'h0000, 0);
            if (i == 2) set_in(24'h999999, 12'h000, 0, 0, 5'h00);
            if (i == 3) l1a = 1'b0;
            @(negedge clk);
            wv[i] = we;
            if (i == 3) begin check("t4_drop", drop, 1); check("t4_cnt", cnt, 1); end
            if (i == 4) begin check("t4_drop_once", drop, 0); check("t4_cnt_hold", cnt, 1); end
        end
        check("t4_we_pattern", wv, 14'h3FE);
        check("t4_busy_end", busy, 0);

        // saturation of a 2-bit drop counter
        do_reset();
        full = 1'b1;
        set_in(24'h000777, 12'h000, 0, 0, 5'h00);
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i == 7) l1a = 1'b0;
            @(negedge clk);
            check("t5_drop", drop, (i >= 3) ? 1 : 0);
            check("t5_drop2", drop2, (i >= 3) ? 1 : 0);
            if (i >= 3) begin
                check("t5_cnt8", cnt, i - 2);
                check("t5_cnt2", cnt2, (i - 2 > 3) ? 3 : i - 2);
            end
        end

        // reset in the middle of Wr_L1H, then a clean record
        do_reset();
        exp_q.push_back(16'hB040);
        exp_q.push_back(16'hC010);
        set_in(24'h000010, 12'h000, 0, 0, 5'h01);
        cyc();
        set_in(24'h000020, 12'h000, 0, 0, 5'h00);
        cyc();
        set_in(24'h000030, 12'h000, 0, 0, 5'h00);
        cyc();
        set_in(24'h000040, 12'h000, 0, 0, 5'h00);
        cyc();
        l1a = 1'b0;
        check("t6_cnt_pre", cnt, 1);
        check("t6_busy_pre", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_we_in_rst", we, 0);
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_we", we, 0);
        check("t6_busy", busy, 0);
        check("t6_cnt", cnt, 0);
        check("t6_exp_drained", exp_q.size(), 0);
        cyc();
        issue(24'h00F00F, 12'h001, 1, 1, 5'h0A, 16'hBAB0, 16'hC00F, 16'hD00F, 16'hE001, 1);
        cyc(); l1a = 1'b0;
        wv = '0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); wv[i] = we; end
        check("t6_we_pattern", wv[5:0], 6'b011110);
        check("t6_busy_end", busy, 0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) cyc();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
